// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Optional round-robin FREE-state policy: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        FREE,
        OWN0,
        OWN1
    } lock_state_t;

    typedef logic port_id_t;

    function automatic logic [NUM_PORTS-1:0] onehot(port_id_t p);
        onehot = p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory arbiter.
// Master = requesters, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    import mem_arb_pkg::*;

    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] req_we;
    logic [NUM_PORTS-1:0] req_lock;
    logic [AW-1:0]        req_addr0;
    logic [AW-1:0]        req_addr1;
    logic [DW-1:0]        req_wdata0;
    logic [DW-1:0]        req_wdata1;
    logic [NUM_PORTS-1:0] rsp_valid;
    logic [DW-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock,
        output req_addr0, req_addr1,
        output req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock,
        input  req_addr0, req_addr1,
        input  req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational grant selection for the arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
    input  port_id_t             rr_ptr,
    input  lock_state_t          state,
    input  logic                 yield_en,
    input  port_id_t             yield_id,
    output logic [NUM_PORTS-1:0] grant
);

    logic [NUM_PORTS-1:0] free_gnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        free_gnt = '0;
        if (valid[rr_ptr])
            free_gnt = onehot(rr_ptr);
        else if (valid[~rr_ptr])
            free_gnt = onehot(~rr_ptr);
    end
`else
    logic unused_rr;
    assign unused_rr = rr_ptr;

    always_comb begin
        free_gnt = '0;
        if (valid[0])
            free_gnt = 2'b01;
        else if (valid[1])
            free_gnt = 2'b10;
    end
`endif

    // After a forced lock release the other port jumps the queue once.
    always_comb begin
        grant = free_gnt;
        if (yield_en && valid[yield_id])
            grant = onehot(yield_id);
        unique case (state)
            OWN0: if (valid[0]) grant = 2'b01;
            OWN1: if (valid[1]) grant = 2'b10;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port 16-bit memory system.
// Lock FSM, grant mux, response regs; MEM_ARB_ROUND_ROBIN_EN in picker.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset_L,
    mem_port_arbiter_if.slave bus,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    inout  wire  [DW-1:0]     mem_data
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    lock_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 yield_q, yield_d;
    port_id_t             yield_id_q, yield_id_d;
    port_id_t             rr_q;
    logic [AW-1:0]        addr_q;
    logic [NUM_PORTS-1:0] rsp_v_q;
    logic [DW-1:0]        rdata_q;

    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] grant;
    logic                 gnt;
    port_id_t             gid;
    logic                 sel_we;
    logic                 sel_lock;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;

    mem_arb_picker u_picker (
        .valid    (bus.req_valid),
        .rr_ptr   (rr_q),
        .state    (state_q),
        .yield_en (yield_q),
        .yield_id (yield_id_q),
        .grant    (pick)
    );

    assign grant     = reset_L ? pick : '0;
    assign gnt       = |grant;
    assign gid       = grant[1];
    assign sel_we    = bus.req_we[gid];
    assign sel_lock  = bus.req_lock[gid];
    assign sel_addr  = gid ? bus.req_addr1 : bus.req_addr0;
    assign sel_wdata = gid ? bus.req_wdata1 : bus.req_wdata0;

    assign mem_addr = gnt ? sel_addr : addr_q;
    assign mem_we   = gnt & sel_we;
    assign mem_re   = gnt & ~sel_we;
    assign mem_data = mem_we ? sel_wdata : {DW{1'bz}};

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_v_q;
    assign bus.rsp_rdata = rdata_q;

    // cnt holds grants already taken under the current lock.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        yield_d    = yield_q;
        yield_id_d = yield_id_q;
        if (gnt) begin
            yield_d = 1'b0;
            if (state_q == (gid ? OWN1 : OWN0)) begin
                if (!sel_lock) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
                    state_d    = FREE;
                    cnt_d      = '0;
                    yield_d    = 1'b1;
                    yield_id_d = ~gid;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (sel_lock) begin
                state_d = gid ? OWN1 : OWN0;
                cnt_d   = CW'(1);
            end else begin
                state_d = FREE;
                cnt_d   = '0;
            end
        end else if (state_q != FREE) begin
            state_d = FREE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            yield_q    <= 1'b0;
            yield_id_q <= 1'b0;
            rr_q       <= 1'b0;
            addr_q     <= '0;
            rsp_v_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            yield_q    <= yield_d;
            yield_id_q <= yield_id_d;
            if (gnt) begin
                rr_q   <= ~gid;
                addr_q <= sel_addr;
            end
            rsp_v_q <= mem_re ? onehot(gid) : '0;
            if (mem_re)
                rdata_q <= mem_data;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple memory model.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the round-robin policy.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_L;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    wire  [15:0] mem_data;
    logic [15:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(.AW(16), .DW(16), .LOCK_MAX(8)) dut (
        .clock    (clk),
        .reset_L  (reset_L),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem_re ? mem[mem_addr[7:0]] : 16'hzzzz;

    // Memory contents are reloaded on every clock seen in reset.
    always @(posedge clk) begin
        if (!reset_L) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 16'h0000;
            mem[8'h10] <= 16'h0005;
            mem[8'h40] <= 16'h1234;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_data;
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [1:0]  lk;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  rdy;
        logic        mwe;
        logic        mre;
        logic [15:0] maddr;
        logic [1:0]  rv;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [1:0]  v, we, lk,
        input logic [15:0] a0, a1, d0, d1,
        input logic [1:0]  rdy,
        input logic        mwe, mre,
        input logic [15:0] maddr,
        input logic [1:0]  rv,
        input logic [15:0] rd
    );
        vec_t t;
        t.v = v; t.we = we; t.lk = lk;
        t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.rdy = rdy; t.mwe = mwe; t.mre = mre;
        t.maddr = maddr; t.rv = rv; t.rd = rd;
        return t;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(
        input logic [1:0]  v, we, lk,
        input logic [15:0] a0, a1, d0, d1
    );
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_lock   = lk;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_wdata0 = d0;
        bus.req_wdata1 = d1;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        @(negedge clk);
        set_in(t.v, t.we, t.lk, t.a0, t.a1, t.d0, t.d1);
        #1;
        chk($sformatf("v%0d ready", idx), 32'(bus.req_ready), 32'(t.rdy));
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(t.mwe));
        chk($sformatf("v%0d mem_re", idx), 32'(mem_re), 32'(t.mre));
        chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(t.maddr));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid), 32'(t.rv));
        if (t.rv != 2'b00)
            chk($sformatf("v%0d rsp_rdata", idx), 32'(bus.rsp_rdata), 32'(t.rd));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'h0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, " mem_re"}, 32'(mem_re), 32'h0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
    endtask

    initial begin
        int n0;
        bit got1;
        logic [1:0] p;

        // Burst of reads from both ports: 0x40 holds 1234, 0x10 holds 5.
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            p = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            p = 2'b01;
`endif
            tbl.push_back(mk(2'b11, 2'b00, 2'b00,
                16'h0040, 16'h0010, 16'h0, 16'h0,
                p, 1'b0, 1'b1,
                (p == 2'b01) ? 16'h0040 : 16'h0010,
                p, (p == 2'b01) ? 16'h1234 : 16'h0005));
        end
        // p1 writes BEEF, p0 reads it back, then idle holds address.
        tbl.push_back(mk(2'b10, 2'b10, 2'b00,
            16'h0000, 16'h0040, 16'h0, 16'hBEEF,
            2'b10, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00,
            16'h0040, 16'h0000, 16'h0, 16'h0,
            2'b01, 1'b0, 1'b1, 16'h0040, 2'b01, 16'hBEEF));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00,
            16'h0000, 16'h0000, 16'h0, 16'h0,
            2'b00, 1'b0, 1'b0, 16'h0040, 2'b00, 16'h0));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00,
            16'h0000, 16'h0020, 16'h0, 16'h0,
            2'b10, 1'b0, 1'b1, 16'h0020, 2'b10, 16'h0000));
        // Locked read-subtract-write on 0x10 while p1 waits.
        tbl.push_back(mk(2'b11, 2'b00, 2'b01,
            16'h0010, 16'h0020, 16'h0, 16'h0,
            2'b01, 1'b0, 1'b1, 16'h0010, 2'b01, 16'h0005));
        tbl.push_back(mk(2'b11, 2'b01, 2'b00,
            16'h0010, 16'h0020, 16'h0002, 16'h0,
            2'b01, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00,
            16'h0010, 16'h0020, 16'h0, 16'h0,
            2'b10, 1'b0, 1'b1, 16'h0020, 2'b10, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00,
            16'h0010, 16'h0020, 16'h0, 16'h0,
            2'b01, 1'b0, 1'b1, 16'h0010, 2'b01, 16'h0002));
        // Owner drops valid while locked: p1 wins in that same cycle.
        tbl.push_back(mk(2'b01, 2'b00, 2'b01,
            16'h0040, 16'h0020, 16'h0, 16'h0,
            2'b01, 1'b0, 1'b1, 16'h0040, 2'b01, 16'hBEEF));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00,
            16'h0040, 16'h0020, 16'h0, 16'h0,
            2'b10, 1'b0, 1'b1, 16'h0020, 2'b10, 16'h0000));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00,
            16'h0000, 16'h0000, 16'h0, 16'h0,
            2'b00, 1'b0, 1'b0, 16'h0020, 2'b00, 16'h0));

        reset_L = 1'b0;
        set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        reset_L = 1'b1;

        foreach (tbl[i])
            run_vec(tbl[i], i);

        // Port 0 holds lock with p1 waiting: 8 grants, then p1.
        n0   = 0;
        got1 = 1'b0;
        for (int c = 0; c < 20 && !got1; c++) begin
            @(negedge clk);
            set_in(2'b11, 2'b00, 2'b01,
                16'h0040, 16'h0020, 16'h0, 16'h0);
            #1;
            if (bus.req_ready == 2'b01)
                n0++;
            else if (bus.req_ready == 2'b10)
                got1 = 1'b1;
        end
        chk("lock_max grants", 32'(n0), 32'd8);
        chk("lock_max release", 32'(got1), 32'd1);

        // Reset with a read response about to appear.
        @(negedge clk);
        set_in(2'b01, 2'b00, 2'b00,
            16'h0040, 16'h0000, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        chk("pre-reset rsp_valid", 32'(bus.rsp_valid), 32'h1);
        #1;
        reset_L = 1'b0;
        #1;
        chk_reset_outs("mid reset");
        set_in(2'b11, 2'b00, 2'b00,
            16'h0040, 16'h0020, 16'h0, 16'h0);
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        chk("post-reset grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post-reset rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("post-reset rsp_rdata", 32'(bus.rsp_rdata), 32'h1234);

        @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
